// File: rtl/fxp_pkg.sv
// Shared constants and the saturate/wrap helper for the fixed-point multiplier family.
package fxp_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  // Widest supported operand; the helper works at this width and callers slice down.
  localparam int MAX_W = 32;
  localparam int SW    = 2 * MAX_W + 1;

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] val;
  } sat_t;

  // Range-checks v against a dw-bit signed result and either clamps or keeps the low bits.
  function automatic sat_t sat_wrap(input logic signed [SW-1:0] v,
                                    input int unsigned dw,
                                    input logic sat);
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;
    sat_t r;
    hi    = (SW'(1) << (dw - 1)) - SW'(1);
    lo    = ~hi;
    r.ovf = (v > hi) || (v < lo);
    if (r.ovf && sat) r.val = v[SW-1] ? lo[MAX_W-1:0] : hi[MAX_W-1:0];
    else              r.val = v[MAX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/fxp_rescale.sv
// One lane of Q-format rescaling: optional half-up rounding, arithmetic shift, overflow clamp.
module fxp_rescale
  import fxp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 14,
  parameter int ROUND      = ROUND_HALF_UP,
  parameter int SAT        = 1
) (
  input  logic signed [2*DATA_WIDTH-1:0] prod,
  output logic        [DATA_WIDTH-1:0]   res,
  output logic                           ovf
);

  // One extra bit so the rounding add on the most positive product cannot overflow.
  localparam int IW     = 2 * DATA_WIDTH + 1;
  localparam int RSH    = (FRAC_WIDTH > 0) ? FRAC_WIDTH - 1 : 0;
  localparam bit DO_RND = (ROUND == ROUND_HALF_UP) && (FRAC_WIDTH > 0);
  localparam logic signed [IW-1:0] HALF = DO_RND ? (IW'(1) << RSH) : '0;

  logic signed [IW-1:0] ext;
  logic signed [IW-1:0] rnd_sum;
  logic signed [IW-1:0] shf;
  sat_t                 sr;
  logic                 unused_bits;

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    ext     = IW'(prod);
    rnd_sum = ext + HALF;
    shf     = rnd_sum >>> FRAC_WIDTH;
    sr      = sat_wrap(SW'(shf), DATA_WIDTH, SAT != 0);
    res     = sr.val[DATA_WIDTH-1:0];
    ovf     = sr.ovf;
  end

  // Upper helper bits beyond DATA_WIDTH are don't-care.
  assign unused_bits = ^sr.val;

endmodule

// File: rtl/fxp_mult_pipe.sv
// Multi-lane pipelined signed fixed-point multiplier with rescale, saturation and overflow count.
(* keep_hierarchy = "yes" *)
module fxp_mult_pipe
  import fxp_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_WIDTH  = 14,
  parameter int LANES       = 1,
  parameter int PIPE_STAGES = 3,
  parameter int ROUND       = ROUND_HALF_UP,
  parameter int SAT         = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic                        in_valid,
  input  logic [LANES*DATA_WIDTH-1:0] a,
  input  logic [LANES*DATA_WIDTH-1:0] b,
  input  logic                        clr_cnt,
  output logic                        out_valid,
  output logic [LANES*DATA_WIDTH-1:0] p,
  output logic [LANES-1:0]            ovf,
  output logic [CNT_WIDTH-1:0]        ovf_count
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = LANES * DATA_WIDTH;

  logic [PW-1:0]          a_r;
  logic [PW-1:0]          b_r;
  logic                   v1;
  logic signed [2*DW-1:0] prod_r [LANES];
  logic                   v2;

  logic [DW-1:0]          res_c [LANES];
  logic [LANES-1:0]       ovf_c;
  logic [PW-1:0]          p3_c;

  // Stage 3 onward; index PIPE_STAGES is the output register.
  logic [PW-1:0]          p_d   [3:PIPE_STAGES];
  logic [LANES-1:0]       ovf_d [3:PIPE_STAGES];
  logic                   v_d   [3:PIPE_STAGES];
  logic [CNT_WIDTH-1:0]   cnt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fxp_rescale #(
      .DATA_WIDTH(DATA_WIDTH),
      .FRAC_WIDTH(FRAC_WIDTH),
      .ROUND     (ROUND),
      .SAT       (SAT)
    ) u_rescale (
      .prod(prod_r[i]),
      .res (res_c[i]),
      .ovf (ovf_c[i])
    );
  end

  always_comb begin
    p3_c = '0;
    for (int i = 0; i < LANES; i++) p3_c[i*DW +: DW] = res_c[i];
  end

  // NOTE: sequential state uses non-blocking assignments so every stage reads last cycle's value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_r <= '0;
      b_r <= '0;
      v1  <= 1'b0;
      v2  <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_r[i] <= '0;
      for (int k = 3; k <= PIPE_STAGES; k++) begin
        p_d[k]   <= '0;
        ovf_d[k] <= '0;
        v_d[k]   <= 1'b0;
      end
      cnt <= '0;
    end else begin
      if (ce) begin
        a_r <= a;
        b_r <= b;
        v1  <= in_valid;
        for (int i = 0; i < LANES; i++)
          prod_r[i] <= (2*DW)'($signed(a_r[i*DW +: DW])) * (2*DW)'($signed(b_r[i*DW +: DW]));
        v2       <= v1;
        p_d[3]   <= p3_c;
        ovf_d[3] <= ovf_c;
        v_d[3]   <= v2;
        for (int k = 4; k <= PIPE_STAGES; k++) begin
          p_d[k]   <= p_d[k-1];
          ovf_d[k] <= ovf_d[k-1];
          v_d[k]   <= v_d[k-1];
        end
      end
      // Counts as the overflowing beat enters stage 3, so it leads out_valid on deeper pipes.
      if (clr_cnt)                              cnt <= '0;
      else if (ce && v2 && |ovf_c && cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  assign p         = p_d[PIPE_STAGES];
  assign ovf       = ovf_d[PIPE_STAGES];
  assign out_valid = v_d[PIPE_STAGES];
  assign ovf_count = cnt;

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Self-checking bench: directed Q2.14 vectors, randomized 4-lane stream, counter and reset checks.
module tb_fxp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst, ce, in_valid, clr_cnt;
  logic [15:0] a1, b1;
  logic [63:0] a4, b4;

  logic        v_a, v_b, v_c;
  logic [15:0] p_a, p_b;
  logic [63:0] p_c;
  logic        o_a, o_b;
  logic [3:0]  o_c;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b, cnt_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [63:0] p;
    logic [3:0]  o;
  } beat_t;

  always #5 clk = ~clk;

  fxp_mult_pipe #(.LANES(1), .PIPE_STAGES(3), .ROUND(1), .SAT(1), .CNT_WIDTH(4)) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a1), .b(b1), .clr_cnt(clr_cnt),
    .out_valid(v_a), .p(p_a), .ovf(o_a), .ovf_count(cnt_a));

  fxp_mult_pipe #(.LANES(1), .PIPE_STAGES(3), .ROUND(0), .SAT(0)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a1), .b(b1), .clr_cnt(clr_cnt),
    .out_valid(v_b), .p(p_b), .ovf(o_b), .ovf_count(cnt_b));

  fxp_mult_pipe #(.LANES(4), .PIPE_STAGES(5), .ROUND(1), .SAT(1)) dut_c (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a4), .b(b4), .clr_cnt(clr_cnt),
    .out_valid(v_c), .p(p_c), .ovf(o_c), .ovf_count(cnt_c));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer product, optional +0.5 LSB, floor shift, then range rule.
  function automatic void ref_lane(input logic [15:0] a, input logic [15:0] b, input bit rnd,
                                   input bit sat, output logic [15:0] p, output logic o);
    longint x;
    x = longint'($signed(a)) * longint'($signed(b));
    if (rnd) x = x + 8192;
    x = x >>> 14;
    o = (x > 32767) || (x < -32768);
    if (o && sat) p = (x < 0) ? 16'h8000 : 16'h7FFF;
    else          p = x[15:0];
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom % 8)
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic run_vec(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] pa, input logic oa, input logic [15:0] pb,
                         input logic ob, input int ca, input int cb);
    a1 = a; b1 = b; in_valid = 1'b1; ce = 1'b1;
    step();
    check("lat_edge1", v_a, 1'b0);
    in_valid = 1'b0;
    step();
    check("lat_edge2", v_a, 1'b0);
    step();
    check("valid_a", v_a, 1'b1);
    check("p_a", p_a, pa);
    check("ovf_a", o_a, oa);
    check("cnt_a", cnt_a, 4'(ca));
    check("valid_b", v_b, 1'b1);
    check("p_b", p_b, pb);
    check("ovf_b", o_b, ob);
    check("cnt_b", cnt_b, 16'(cb));
  endtask

  initial begin
    beat_t       q[$];
    beat_t       cur, nb, s3;
    logic [15:0] lp;
    logic        lo;
    int          cnt_m;

    rst = 1'b0; ce = 1'b1; in_valid = 1'b1; clr_cnt = 1'b0;
    a1 = 16'h4000; b1 = 16'h4000; a4 = '1; b4 = '1;
    step(); step();
    check("rst_valid_a", v_a, 1'b0);
    check("rst_p_a", p_a, 16'h0);
    check("rst_cnt_a", cnt_a, 4'h0);
    check("rst_valid_c", v_c, 1'b0);
    check("rst_p_c", p_c, 64'h0);
    check("rst_ovf_c", o_c, 4'h0);
    rst = 1'b1; in_valid = 1'b0;

    // Directed Q2.14 vectors: a, b, then {p, ovf, count} for round+sat and trunc+wrap.
    run_vec(16'd8192,  16'd8192,  16'd4096,  1'b0, 16'd4096,  1'b0, 0, 0);
    run_vec(16'h8000,  16'h8000,  16'h7FFF,  1'b1, 16'h0000,  1'b1, 1, 1);
    run_vec(16'd1,     16'd8192,  16'h0001,  1'b0, 16'h0000,  1'b0, 1, 1);
    run_vec(16'hFFFF,  16'd8192,  16'h0000,  1'b0, 16'hFFFF,  1'b0, 1, 1);
    run_vec(16'h8000,  16'h7FFF,  16'h8000,  1'b1, 16'h0002,  1'b1, 2, 2);
    run_vec(16'h7FFF,  16'd16384, 16'h7FFF,  1'b0, 16'h7FFF,  1'b0, 2, 2);
    run_vec(16'h8000,  16'd16384, 16'h8000,  1'b0, 16'h8000,  1'b0, 2, 2);

    // Randomized 4-lane stream with ce gaps against a queue model of the enabled-edge pipeline.
    rst = 1'b0; step(); rst = 1'b1;
    q = {};
    for (int i = 0; i < 4; i++) q.push_back('{v: 1'b0, p: 64'h0, o: 4'h0});
    cur = '{v: 1'b0, p: 64'h0, o: 4'h0};
    cnt_m = 0;
    for (int n = 0; n < 400; n++) begin
      ce       = ($urandom % 4) != 0;
      in_valid = ($urandom % 5) != 0;
      for (int l = 0; l < 4; l++) begin
        a4[l*16 +: 16] = rnd16();
        b4[l*16 +: 16] = rnd16();
      end
      nb.v = in_valid;
      nb.p = '0;
      nb.o = '0;
      for (int l = 0; l < 4; l++) begin
        ref_lane(a4[l*16 +: 16], b4[l*16 +: 16], 1'b1, 1'b1, lp, lo);
        nb.p[l*16 +: 16] = lp;
        nb.o[l] = lo;
      end
      step();
      if (ce) begin
        q.push_back(nb);
        s3 = q[q.size() - 3];
        if (s3.v && (|s3.o) && cnt_m != 65535) cnt_m++;
        cur = q.pop_front();
      end
      check("rnd_valid", v_c, cur.v);
      check("rnd_p", p_c, cur.p);
      check("rnd_ovf", o_c, cur.o);
      check("rnd_cnt", cnt_c, 16'(cnt_m));
    end

    // Saturating 4-bit counter, then clear priority over increment and over ce.
    rst = 1'b0; step(); rst = 1'b1;
    ce = 1'b1; in_valid = 1'b1; a1 = 16'h8000; b1 = 16'h8000;
    step(); step();
    check("cnt_before_s3", cnt_a, 4'd0);
    step();
    check("cnt_first", cnt_a, 4'd1);
    for (int i = 0; i < 20; i++) step();
    check("cnt_sat", cnt_a, 4'd15);
    clr_cnt = 1'b1; step();
    check("cnt_clr_wins", cnt_a, 4'd0);
    clr_cnt = 1'b0; step();
    check("cnt_after_clr", cnt_a, 4'd1);
    ce = 1'b0; clr_cnt = 1'b1; step();
    check("cnt_clr_no_ce", cnt_a, 4'd0);
    clr_cnt = 1'b0; step();
    check("cnt_hold_no_ce", cnt_a, 4'd0);

    // Reset with beats in flight: outputs clear at once and nothing stale emerges afterwards.
    ce = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int l = 0; l < 4; l++) a4[l*16 +: 16] = 16'h8000;
      b4 = {4{16'h8000}};
      step();
    end
    rst = 1'b0; step();
    check("mid_rst_valid_c", v_c, 1'b0);
    check("mid_rst_p_c", p_c, 64'h0);
    check("mid_rst_ovf_c", o_c, 4'h0);
    check("mid_rst_cnt_c", cnt_c, 16'h0);
    check("mid_rst_valid_a", v_a, 1'b0);
    check("mid_rst_cnt_a", cnt_a, 4'h0);
    rst = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_valid_c", v_c, 1'b0);
      check("post_rst_valid_a", v_a, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
